// File: rtl/matrix_column_scanner_if.sv
// matrix_column_scanner_if: column patterns in, LED matrix drive and display-alternation control out.
interface matrix_column_scanner_if;
  logic       enable;
  logic [6:0] col_4, col_3, col_2, col_1, col_0;
  logic [6:0] row_out;
  logic [4:0] col_sel;
  logic       selector;
  logic       frame_tick;
  modport master (
    output enable, col_4, col_3, col_2, col_1, col_0,
    input  row_out, col_sel, selector, frame_tick
  );
  modport slave (
    input  enable, col_4, col_3, col_2, col_1, col_0,
    output row_out, col_sel, selector, frame_tick
  );
endinterface

// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: time-multiplexes a 5x7 LED matrix one column at a time from a per-frame snapshot.
module matrix_column_scanner #(
  parameter int SCAN_DIV       = 10000,
  parameter int BLANK_CYCLES   = 100,
  parameter int ALT_FRAMES     = 250,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int COL_ACTIVE_LOW = 1
) (
  input logic                    clk,
  input logic                    reset,
  matrix_column_scanner_if.slave bus
);
  typedef enum logic [1:0] {OFF, LOAD, BLANK, DRIVE} state_t;
  localparam int TMAX = SCAN_DIV > BLANK_CYCLES ? SCAN_DIV : BLANK_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int FW = ALT_FRAMES > 1 ? $clog2(ALT_FRAMES) : 1;
  localparam logic [TW-1:0] SCAN_END = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [FW-1:0] FRAME_END = FW'(ALT_FRAMES - 1);
  localparam logic [6:0] ROW_OFF = ROW_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic [4:0] COL_OFF = COL_ACTIVE_LOW != 0 ? 5'h1F : 5'h00;
  localparam state_t GAP = BLANK_CYCLES > 0 ? BLANK : DRIVE;
  state_t          state, state_n;
  logic [2:0]      col_idx, col_idx_n;
  logic [TW-1:0]   timer, timer_n;
  logic [FW-1:0]   frame_cnt, frame_cnt_n;
  logic            selector, selector_n, tick_n, done;
  logic [4:0][6:0] fb, fb_n;
  logic [6:0]      row_n;
  logic [4:0]      col_n;
  assign bus.selector = selector;
  always_comb begin
    state_n = state;
    col_idx_n = col_idx;
    frame_cnt_n = frame_cnt;
    selector_n = selector;
    tick_n = 1'b0;
    done = 1'b0;
    fb_n = state == LOAD ? {bus.col_4, bus.col_3, bus.col_2, bus.col_1, bus.col_0} : fb;
    case (state)
      OFF: begin
        state_n = LOAD;
        done = 1'b1;
      end
      LOAD: begin
        state_n = GAP;
        col_idx_n = 3'd4;
        done = 1'b1;
      end
      BLANK: if (timer == BLANK_END) begin
        state_n = DRIVE;
        done = 1'b1;
      end
      DRIVE: if (timer == SCAN_END) begin
        done = 1'b1;
        if (col_idx != 3'd0) begin
          col_idx_n = col_idx - 3'd1;
          state_n = GAP;
        end else begin
          state_n = LOAD;
          tick_n = 1'b1;
          frame_cnt_n = frame_cnt == FRAME_END ? '0 : frame_cnt + FW'(1);
          selector_n = selector ^ (frame_cnt == FRAME_END);
        end
      end
      default: state_n = OFF;
    endcase
    // Disable beats a coincident frame end: no tick, no count, no toggle.
    if (!bus.enable) begin
      state_n = OFF;
      col_idx_n = col_idx;
      frame_cnt_n = frame_cnt;
      selector_n = selector;
      tick_n = 1'b0;
      done = 1'b1;
    end
    timer_n = done ? '0 : timer + TW'(1);
    row_n = state_n == DRIVE ? fb_n[col_idx_n] ^ ROW_OFF : ROW_OFF;
    col_n = state_n == DRIVE ? (5'd1 << col_idx_n) ^ COL_OFF : COL_OFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OFF;
      col_idx <= 3'd4;
      timer <= '0;
      frame_cnt <= '0;
      selector <= 1'b1;
      fb <= '0;
      bus.row_out <= ROW_OFF;
      bus.col_sel <= COL_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      state <= state_n;
      col_idx <= col_idx_n;
      timer <= timer_n;
      frame_cnt <= frame_cnt_n;
      selector <= selector_n;
      fb <= fb_n;
      bus.row_out <= row_n;
      bus.col_sel <= col_n;
      bus.frame_tick <= tick_n;
    end
  end
endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner: vector table, hand sequences and randomized run against a frame-position model.
module tb_matrix_column_scanner;
  localparam int S = 4, B = 1, A = 2, FRAME = 1 + 5 * (B + S);
  typedef struct {
    int         n;
    logic [6:0] row;
    logic [4:0] col;
    logic       tick;
    logic       sel;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  matrix_column_scanner_if bus();
  matrix_column_scanner #(
    .SCAN_DIV(S), .BLANK_CYCLES(B), .ALT_FRAMES(A), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  int checks = 0, errors = 0, cyc = 0, rel = 0;
  bit m_on = 1'b0, m_sel = 1'b1, m_tick = 1'b0;
  int m_pos = 0, m_cnt = 0;
  logic [6:0] m_buf [5] = '{default: 7'h00};
  vec_t tbl [13];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] col_in(int c);
    case (c)
      4: return bus.col_4;
      3: return bus.col_3;
      2: return bus.col_2;
      1: return bus.col_1;
      default: return bus.col_0;
    endcase
  endfunction

  // Column currently driven according to position within the frame, -1 when dark.
  function automatic int cur_col();
    if (!m_on || m_pos == 0) return -1;
    if ((m_pos - 1) % (B + S) < B) return -1;
    return 4 - (m_pos - 1) / (B + S);
  endfunction

  task automatic model_edge();
    m_tick = 1'b0;
    if (rst) begin
      m_on = 1'b0;
      m_sel = 1'b1;
      m_cnt = 0;
      for (int i = 0; i < 5; i++) m_buf[i] = 7'h00;
    end else if (!bus.enable) m_on = 1'b0;
    else if (!m_on) begin
      m_on = 1'b1;
      m_pos = 0;
    end else begin
      if (m_pos == 0) for (int i = 0; i < 5; i++) m_buf[i] = col_in(i);
      m_pos++;
      if (m_pos == FRAME) begin
        m_pos = 0;
        m_tick = 1'b1;
        m_cnt++;
        if (m_cnt == A) begin
          m_cnt = 0;
          m_sel = !m_sel;
        end
      end
    end
  endtask

  task automatic step();
    int c;
    logic [6:0] e_row;
    logic [4:0] e_col;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    c = cur_col();
    e_row = c < 0 ? 7'h7F : ~m_buf[c];
    e_col = c < 0 ? 5'h1F : ~(5'd1 << c);
    chk("model.row_out", 32'(bus.row_out), 32'(e_row));
    chk("model.col_sel", 32'(bus.col_sel), 32'(e_col));
    chk("model.frame_tick", 32'(bus.frame_tick), 32'(m_tick));
    chk("model.selector", 32'(bus.selector), 32'(m_sel));
  endtask

  task automatic goto(int n);
    int g = 0;
    while (cyc - rel < n && g < 1000) begin
      step();
      g++;
    end
  endtask

  task automatic expect_out(string nm, logic [6:0] r, logic [4:0] c, logic t, logic s);
    chk({nm, ".row_out"}, 32'(bus.row_out), 32'(r));
    chk({nm, ".col_sel"}, 32'(bus.col_sel), 32'(c));
    chk({nm, ".frame_tick"}, 32'(bus.frame_tick), 32'(t));
    chk({nm, ".selector"}, 32'(bus.selector), 32'(s));
  endtask

  initial begin
    tbl = '{
      '{1,  7'h7F, 5'h1F, 1'b0, 1'b1}, '{2,  7'h7F, 5'h1F, 1'b0, 1'b1},
      '{3,  7'h7E, 5'h0F, 1'b0, 1'b1}, '{6,  7'h7E, 5'h0F, 1'b0, 1'b1},
      '{7,  7'h7F, 5'h1F, 1'b0, 1'b1}, '{8,  7'h7F, 5'h17, 1'b0, 1'b1},
      '{12, 7'h7F, 5'h1F, 1'b0, 1'b1}, '{13, 7'h7F, 5'h1B, 1'b0, 1'b1},
      '{18, 7'h7F, 5'h1D, 1'b0, 1'b1}, '{22, 7'h7F, 5'h1F, 1'b0, 1'b1},
      '{23, 7'h3F, 5'h1E, 1'b0, 1'b1}, '{26, 7'h3F, 5'h1E, 1'b0, 1'b1},
      '{27, 7'h7F, 5'h1F, 1'b1, 1'b1}
    };
    bus.enable = 1'b1;
    bus.col_4 = 7'h01;
    bus.col_3 = 7'h00;
    bus.col_2 = 7'h00;
    bus.col_1 = 7'h00;
    bus.col_0 = 7'h40;
    repeat (3) begin
      step();
      expect_out("reset", 7'h7F, 5'h1F, 1'b0, 1'b1);
    end
    rst = 1'b0;
    rel = cyc;
    foreach (tbl[i]) begin
      goto(tbl[i].n);
      expect_out($sformatf("vec%0d", i), tbl[i].row, tbl[i].col, tbl[i].tick, tbl[i].sel);
    end
    goto(35);
    bus.col_2 = 7'h7F;
    goto(40);
    expect_out("col2_old", 7'h7F, 5'h1B, 1'b0, 1'b1);
    goto(52);
    chk("no_tick_52", 32'(bus.frame_tick), 32'd0);
    goto(53);
    expect_out("tick2", 7'h7F, 5'h1F, 1'b1, 1'b0);
    goto(66);
    expect_out("col2_new", 7'h00, 5'h1B, 1'b0, 1'b0);
    goto(79);
    expect_out("tick3", 7'h7F, 5'h1F, 1'b1, 1'b0);
    goto(105);
    expect_out("tick4", 7'h7F, 5'h1F, 1'b1, 1'b1);
    goto(123);
    expect_out("col1", 7'h7F, 5'h1D, 1'b0, 1'b1);
    bus.enable = 1'b0;
    goto(124);
    expect_out("disable", 7'h7F, 5'h1F, 1'b0, 1'b1);
    goto(127);
    bus.enable = 1'b1;
    goto(128);
    expect_out("reload", 7'h7F, 5'h1F, 1'b0, 1'b1);
    goto(130);
    expect_out("restart_c4", 7'h7E, 5'h0F, 1'b0, 1'b1);
    repeat (600) begin
      step();
      if ($urandom_range(0, 7) == 0) begin
        bus.col_4 = 7'($urandom);
        bus.col_3 = 7'($urandom);
        bus.col_2 = 7'($urandom);
        bus.col_1 = 7'($urandom);
        bus.col_0 = 7'($urandom);
      end
      bus.enable = $urandom_range(0, 59) != 0;
    end
    bus.enable = 1'b1;
    for (int g = 0; g < 300 && m_sel; g++) step();
    chk("sel_wait", 32'(bus.selector), 32'd0);
    repeat (9) step();
    rst = 1'b1;
    step();
    expect_out("mid_reset", 7'h7F, 5'h1F, 1'b0, 1'b1);
    rst = 1'b0;
    rel = cyc;
    goto(27);
    expect_out("post_reset_tick1", 7'h7F, 5'h1F, 1'b1, 1'b1);
    goto(53);
    expect_out("post_reset_tick2", 7'h7F, 5'h1F, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_column_scanner.md
Name: matrix_column_scanner

Overview:
- Drives the physical 5x7 LED matrix from the five 7-bit column patterns produced by the display-mode logic.
- Time-multiplexes one column at a time, with a blanking gap between columns to prevent ghosting.
- Snapshots the patterns once per frame so a column never changes mid-frame (no tearing).
- Generates the `selector` signal that alternates the upstream display between the state image and the water-level image every ALT_FRAMES frames.

Parameters:
- SCAN_DIV, 10000: clock cycles each column is actively driven (>=1).
- BLANK_CYCLES, 100: all-off clock cycles before each column is driven (>=0; 0 means no BLANK state).
- ALT_FRAMES, 250: complete frames between `selector` toggles (>=1).
- ROW_ACTIVE_LOW, 1: 1 means `row_out` bits are driven low for a lit LED.
- COL_ACTIVE_LOW, 1: 1 means the selected `col_sel` bit is driven low.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  scanning on; low blanks the matrix.
- col_4  input  7  pattern for column 4, bit 0 = top row, 1 = LED lit.
- col_3  input  7  pattern for column 3.
- col_2  input  7  pattern for column 2.
- col_1  input  7  pattern for column 1.
- col_0  input  7  pattern for column 0.
- row_out  output  7  row drive, polarity per ROW_ACTIVE_LOW.
- col_sel  output  5  column enables, bit n = column n, one-hot when driving, polarity per COL_ACTIVE_LOW.
- selector  output  1  1 = state image, 0 = water-level image; fed back to the display-mode block.
- frame_tick  output  1  one-cycle pulse at the end of each complete frame.

Behaviour:
- Outputs are registered. The "inactive" level for `row_out` and `col_sel` is all-1s when the corresponding ACTIVE_LOW parameter is 1, and all-0s otherwise.
- Reset values: state=OFF, `row_out`/`col_sel` inactive, `selector`=1, `frame_tick`=0, col_idx=4, frame_cnt=0, timer=0, frame buffer=0.
- OFF: outputs inactive. If `enable`=1, go to LOAD on the next edge.
- LOAD (1 cycle): capture col_4..col_0 into the frame buffer and set col_idx=4. Go to BLANK, or to DRIVE if BLANK_CYCLES=0. Outputs are inactive during LOAD.
- BLANK: lasts exactly BLANK_CYCLES cycles with all outputs inactive, then go to DRIVE.
- DRIVE: lasts exactly SCAN_DIV cycles.
  - `col_sel` has only bit col_idx active.
  - `row_out` = buffer[col_idx], inverted if ROW_ACTIVE_LOW=1.
- End of DRIVE, col_idx>0: decrement col_idx, then go to BLANK (or DRIVE if BLANK_CYCLES=0).
- End of DRIVE, col_idx=0 (frame end):
  - Pulse `frame_tick` for the next cycle.
  - If frame_cnt=ALT_FRAMES-1, toggle `selector` and set frame_cnt=0; otherwise increment frame_cnt.
  - Go to LOAD.
- Frame length: 1 + 5*(BLANK_CYCLES+SCAN_DIV) cycles.
- Input patterns are sampled only in LOAD. Changes at any other time appear from the next frame onward.
- `enable` deasserted in any state:
  - Next edge goes to OFF with outputs inactive and the partial frame discarded.
  - `selector` and frame_cnt hold their values; no `frame_tick` is issued.
- Re-enable always restarts at LOAD, column 4.
- Simultaneous frame end and `enable`=0: OFF wins. No tick, no count, no toggle.
- `reset` overrides everything, including mid-frame. It restores the reset values on the next edge.
- Counters are sized with $clog2 of their maximum value; the timer wraps to 0 on every state change.
- The `selector` toggle and the `frame_tick` pulse are registered in the same cycle.

Test Plan:
All scenarios use SCAN_DIV=4, BLANK_CYCLES=1, ALT_FRAMES=2 and both ACTIVE_LOW parameters at 1, giving a frame length of 26 cycles.
- Reset held for 3 cycles, `enable`=1 -> during reset `row_out`=7'h7F, `col_sel`=5'h1F, `selector`=1; the first DRIVE begins 2 cycles after release.
- col_4=7'h01 and col_0=7'h40, others 0 -> column 4 window shows `col_sel`=5'h0F and `row_out`=7'h7E for 4 cycles; column 0 window shows `col_sel`=5'h1E and `row_out`=7'h3F. Exactly one all-off cycle separates each pair of columns.
- Change col_2 from 0 to 7'h7F while column 3 is being driven -> column 2 in the current frame shows `row_out`=7'h7F (unlit); the next frame shows 7'h00.
- Run 4 frames -> `frame_tick` pulses every 26 cycles; `selector` reads 1, 0 after the 2nd tick, and 1 after the 4th tick, toggling on the same edge as the tick.
- Drop `enable` during column 1 of frame 1 -> outputs inactive on the next edge, no tick, `selector` unchanged. Re-enable -> LOAD, then column 4 first.
- Assert `reset` mid-frame with `selector`=0 -> next edge gives `selector`=1, frame_cnt=0 and outputs inactive.
